// File: rtl/pc_sequencer.sv
// Program-counter sequencer: after a program load, walks the core through
// UPDATE -> FETCH -> EXEC per instruction and stops on jump-to-self or an illegal target.
module pc_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] PC_LIMIT   = 32'h0000_03FC
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  load_start,
  input  logic                  load_done,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  input  logic                  imem_valid,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  pc_load,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic                  running,
  output logic                  halted,
  output logic                  error,
  output logic [31:0]           retired_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_FETCH, S_EXEC, S_HALT, S_ERROR
  } state_t;

  state_t                  state;
  logic [1:0]              rst_sync;
  logic                    rst_n;
  logic [DATA_WIDTH-1:0]   target;
  logic                    target_bad;
  logic [31:0]             count_inc;

  // Reset asserts asynchronously, releases two clk edges after arst_n rises.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign target     = branch_taken ? branch_target : pc_cur + DATA_WIDTH'(4);
  assign target_bad = (target > PC_LIMIT) || (target[1:0] != 2'b00);
  assign count_inc  = (retired_count == 32'hFFFF_FFFF) ? retired_count : retired_count + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc_next       <= RESET_PC;
      retired_count <= '0;
    end else if (load_start) begin
      // Loader owns the memory now; count is kept until the new program starts.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (load_done) begin
          state         <= S_UPDATE;
          pc_next       <= RESET_PC;
          retired_count <= '0;
        end
        S_UPDATE: state <= S_FETCH;
        S_FETCH:  if (imem_valid) state <= S_EXEC;
        S_EXEC: if (!stall) begin
          if (target == pc_cur) begin
            state         <= S_HALT;
            retired_count <= count_inc;
          end else if (target_bad) begin
            state <= S_ERROR;
          end else begin
            state         <= S_UPDATE;
            pc_next       <= target;
            retired_count <= count_inc;
          end
        end
        S_HALT:   state <= S_HALT;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign pc_load  = (state == S_UPDATE);
  assign imem_req = (state == S_FETCH);
  assign running  = (state == S_UPDATE) || (state == S_FETCH) || (state == S_EXEC);
  assign halted   = (state == S_HALT);
  assign error    = (state == S_ERROR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instruction vectors push expected
// pc_load / halt / error events; a negedge monitor pops and compares them.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        load_start = 1'b0, load_done = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        imem_valid = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        pc_load, imem_req, running, halted, error;
  logic [31:0] pc_next, retired_count;

  pc_sequencer dut (
    .clk(clk), .arst_n(arst_n), .load_start(load_start), .load_done(load_done),
    .pc_cur(pc_cur), .imem_valid(imem_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_load(pc_load), .pc_next(pc_next), .imem_req(imem_req), .running(running),
    .halted(halted), .error(error), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_LOAD, EV_HALT, EV_ERR} ev_t;
  typedef struct {
    ev_t         kind;
    logic [31:0] pc;
    logic [31:0] cnt;
    int          gap;   // expected cycles since previous pc_load, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, last_load = 0;
  logic halted_q = 1'b0, error_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input ev_t k, input logic [31:0] pc, input logic [31:0] cnt, input int gap);
    exp_t e;
    e.kind = k; e.pc = pc; e.cnt = cnt; e.gap = gap;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT event consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (pc_load || (halted && !halted_q) || (error && !error_q)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {29'd0, error, halted, pc_load}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (pc_load) begin
          chk("ev_kind_load", 32'(e.kind), 32'(EV_LOAD));
          chk("load_pc_next", pc_next, e.pc);
          chk("load_retired", retired_count, e.cnt);
          if (e.gap != 0) chk("load_period", 32'(cyc - last_load), 32'(e.gap));
          last_load = cyc;
        end else if (halted) begin
          chk("ev_kind_halt", 32'(e.kind), 32'(EV_HALT));
          chk("halt_retired", retired_count, e.cnt);
        end else begin
          chk("ev_kind_err", 32'(e.kind), 32'(EV_ERR));
          chk("err_retired", retired_count, e.cnt);
        end
      end
    end
    halted_q <= halted;
    error_q  <= error;
  end

  task automatic pulse_done();
    load_done = 1'b1; @(negedge clk); load_done = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    if (!imem_req) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  // One instruction: called at a negedge, returns at the negedge after EXEC resolves.
  task automatic instr(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                       input int fdly, input int stl);
    pc_cur = pc;
    wait_fetch();
    repeat (fdly) @(negedge clk);
    imem_valid = 1'b1; @(negedge clk); imem_valid = 1'b0;
    stall = 1'b1;
    repeat (stl) @(negedge clk);
    stall = 1'b0; branch_taken = br; branch_target = tgt;
    @(negedge clk);
    branch_taken = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_flags", {30'd0, halted, error}, 32'd0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_retired", retired_count, 32'h0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    // Stray imem_valid in IDLE must be ignored
    imem_valid = 1'b1; @(negedge clk); imem_valid = 1'b0;
    chk("idle_ignores_valid", {30'd0, running, imem_req}, 32'd0);

    // Start, sequential run 0,4,8
    push(EV_LOAD, 32'h0, 32'd0, 0);
    push(EV_LOAD, 32'h4, 32'd1, 3);
    push(EV_LOAD, 32'h8, 32'd2, 3);
    push(EV_LOAD, 32'hC, 32'd3, 3);
    pulse_done();
    instr(32'h0, 1'b0, 32'h0, 0, 0);
    instr(32'h4, 1'b0, 32'h0, 0, 0);
    instr(32'h8, 1'b0, 32'h0, 0, 0);
    // Fetch wait 2 cycles, stall 5 cycles
    push(EV_LOAD, 32'h10, 32'd4, 10);
    instr(32'hC, 1'b0, 32'h0, 2, 5);
    // Jump-to-self halts
    push(EV_HALT, 32'h0, 32'd5, 0);
    instr(32'h10, 1'b1, 32'h10, 0, 0);
    repeat (3) @(negedge clk);
    chk("halt_sticky", {30'd0, halted, running}, 32'd2);
    chk("halt_pc_next_held", pc_next, 32'h10);
    pulse_start();
    chk("start_clears_halt", {31'd0, halted}, 32'd0);
    chk("start_keeps_count", retired_count, 32'd5);

    // Misaligned target
    push(EV_LOAD, 32'h0, 32'd0, 0);
    push(EV_ERR, 32'h0, 32'd0, 0);
    pulse_done();
    instr(32'h0, 1'b1, 32'h402, 0, 0);
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_pc_next_held", pc_next, 32'h0);
    pulse_start();
    chk("start_clears_err", {31'd0, error}, 32'd0);

    // Limit boundary: 0x3FC legal, 0x400 illegal
    push(EV_LOAD, 32'h0, 32'd0, 0);
    push(EV_LOAD, 32'h3FC, 32'd1, 3);
    push(EV_ERR, 32'h0, 32'd1, 0);
    pulse_done();
    instr(32'h0, 1'b1, 32'h3FC, 0, 0);
    instr(32'h3FC, 1'b0, 32'h0, 0, 0);
    chk("err_limit_flag", {31'd0, error}, 32'd1);
    pulse_start();

    // pc_cur+4 wraps to zero
    push(EV_LOAD, 32'h0, 32'd0, 0);
    push(EV_LOAD, 32'h0, 32'd1, 3);
    push(EV_LOAD, 32'h20, 32'd2, 3);
    pulse_done();
    instr(32'hFFFF_FFFC, 1'b0, 32'h0, 0, 0);
    instr(32'h0, 1'b1, 32'h20, 0, 0);

    // Async reset in FETCH
    pc_cur = 32'h20;
    wait_fetch();
    #2 arst_n = 1'b0;
    #1;
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_running", {30'd0, running, pc_load}, 32'd0);
    chk("arst_pc_next", pc_next, 32'h0);
    chk("arst_retired", retired_count, 32'd0);
    @(negedge clk); arst_n = 1'b1;
    repeat (3) @(negedge clk);

    // load_start wins over load_done
    load_start = 1'b1; load_done = 1'b1;
    @(negedge clk);
    load_start = 1'b0; load_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_wins_idle", {30'd0, running, pc_load}, 32'd0);

    push(EV_LOAD, 32'h0, 32'd0, 0);
    pulse_done();
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all PC/address buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, program start address loaded after each program load.
REQ-003 Parameter PC_LIMIT, default 32'h0000_03FC, highest legal instruction address.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 load_start  input  1  UART loader has begun writing instruction memory; one-cycle pulse.
REQ-007 load_done  input  1  program fully written to instruction memory; one-cycle pulse.
REQ-008 pc_cur  input  DATA_WIDTH  current PC from the program counter register.
REQ-009 imem_valid  input  1  instruction memory returns instruction for pc_cur.
REQ-010 stall  input  1  execute stage not finished; hold current instruction.
REQ-011 branch_taken  input  1  current instruction redirects flow; sampled only in EXEC.
REQ-012 branch_target  input  DATA_WIDTH  redirect address; sampled only in EXEC when branch_taken=1.
REQ-013 pc_load  output  1  load enable to program counter (drives its prog_ready).
REQ-014 pc_next  output  DATA_WIDTH  value loaded into program counter when pc_load=1.
REQ-015 imem_req  output  1  instruction fetch request for address pc_cur.
REQ-016 running  output  1  high in UPDATE, FETCH, EXEC.
REQ-017 halted  output  1  program finished (jump-to-self); sticky.
REQ-018 error  output  1  illegal next PC detected; sticky.
REQ-019 retired_count  output  32  instructions completed since last load_done.

Function
REQ-020 States SHALL be IDLE, UPDATE, FETCH, EXEC, HALT, ERROR; all outputs SHALL be registered or decoded from state only (Moore).
REQ-021 IDLE: on load_done -> UPDATE, pc_next<=RESET_PC, retired_count<=0.
REQ-022 UPDATE: pc_load=1 for exactly this one cycle; always -> FETCH next cycle.
REQ-023 FETCH: imem_req=1; stay until imem_valid=1, then -> EXEC; imem_valid outside FETCH SHALL be ignored.
REQ-024 EXEC with stall=1: hold EXEC, no output change.
REQ-025 EXEC with stall=0: target = branch_taken ? branch_target : pc_cur+4, modulo 2^DATA_WIDTH (wrap, no carry out).
REQ-026 If target == pc_cur: -> HALT, retired_count+1, no pc_load.
REQ-027 Else if target > PC_LIMIT or target[1:0] != 2'b00: -> ERROR, retired_count unchanged, no pc_load.
REQ-028 Else: pc_next<=target, retired_count+1, -> UPDATE.
REQ-029 Minimum instruction period SHALL be 3 cycles (UPDATE, FETCH with imem_valid, EXEC with stall=0).
REQ-030 retired_count SHALL saturate at 32'hFFFF_FFFF.
REQ-031 HALT: halted=1; ERROR: error=1; both held until load_start or reset.
REQ-032 load_start in any state SHALL force IDLE next cycle, clear halted and error, suppress pc_load; retired_count held until next load_done.
REQ-033 load_start and load_done in the same cycle: load_start wins, next state IDLE.
REQ-034 load_done outside IDLE SHALL be ignored.
REQ-035 pc_next SHALL hold its last value whenever pc_load=0.

Reset
REQ-036 On arst_n=0, immediately and independent of clk: state=IDLE, pc_load=0, pc_next=RESET_PC, imem_req=0, running=0, halted=0, error=0, retired_count=0.
REQ-037 Reset assertion mid-operation SHALL abort any state with no further pc_load; deassertion SHALL be synchronized to clk before leaving IDLE.

Verification
REQ-038 Reset, load_done pulse -> UPDATE with pc_load=1, pc_next=0 one cycle, then FETCH imem_req=1.
REQ-039 Sequential run: pc_cur 0,4,8 with imem_valid immediate, no stall -> pc_next 4,8,C, pc_load every 3rd cycle, retired_count=3.
REQ-040 Branch_taken with branch_target=pc_cur=0x10 -> HALT, halted=1, retired_count incremented, no pc_load.
REQ-041 branch_target=0x0000_0402 or 0x0000_0400 -> ERROR, error=1, no pc_load; load_start -> IDLE, error=0.
REQ-042 stall held 5 cycles in EXEC, imem_valid delayed 2 cycles in FETCH -> no pc_load during waits, period 3+5+2 cycles.
REQ-043 arst_n pulled low in FETCH -> all outputs at reset values before the next clk edge; load_start and load_done together -> IDLE.
